// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler
//
// Sequences the external PRBS generator into AXI-Stream frames. The block
// seeds the generator (o_prbs_load) and then steps it one word at a time
// (o_prbs_advance). Each word is captured into a single output register
// that obeys AXI-Stream hold rules under backpressure.
//
// Ports
//   s_axi_aclk, s_axi_aresetn   clock, asynchronous active-low reset
//   i_start / i_abort           single-cycle run control pulses
//   i_frame_len                 words per frame (0 makes i_start a no-op)
//   i_gap_len                   idle cycles between frames
//   i_num_frames                frames per run (0 = run until abort)
//   i_seed                      generator seed; the generator samples it
//                               itself when o_prbs_load is high
//   o_prbs_load, o_prbs_advance generator control
//   i_prbs_data                 current generator word
//   m_axis_*                    framed output stream (sof/tlast markers)
//   o_busy, o_done              run status; o_done pulses once per run end
//   o_frames_sent               tlast handshakes in the current/last run
module tx_frame_scheduler #(
  parameter int C_LEN_WIDTH = 16,
  parameter int C_GAP_WIDTH = 8,
  parameter int C_CNT_WIDTH = 16
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [C_LEN_WIDTH-1:0] i_frame_len,
  input  logic [C_GAP_WIDTH-1:0] i_gap_len,
  input  logic [C_CNT_WIDTH-1:0] i_num_frames,
  input  logic [31:0]            i_seed,
  output logic                   o_prbs_load,
  output logic                   o_prbs_advance,
  input  logic [31:0]            i_prbs_data,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_sof,
  output logic                   m_axis_tlast,
  output logic [31:0]            m_axis_tdata,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [C_CNT_WIDTH-1:0] o_frames_sent
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [C_LEN_WIDTH-1:0] len_q, len_d;
  logic [C_LEN_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [C_GAP_WIDTH-1:0] gap_q, gap_d;
  logic [C_GAP_WIDTH-1:0] gcnt_q, gcnt_d;
  logic [C_CNT_WIDTH-1:0] num_q, num_d;
  logic [C_CNT_WIDTH-1:0] floaded_q, floaded_d;
  logic [C_CNT_WIDTH-1:0] fsent_q, fsent_d;
  logic [C_CNT_WIDTH-1:0] floaded_inc;
  logic                   tvalid_q, tvalid_d;
  logic                   sof_q, sof_d;
  logic                   tlast_q, tlast_d;
  logic [31:0]            tdata_q, tdata_d;
  logic                   done_q, done_d;
  logic                   slot_free;
  logic                   word_is_last;
  logic                   load_c;
  logic                   adv_c;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      wcnt_q    <= '0;
      gap_q     <= '0;
      gcnt_q    <= '0;
      num_q     <= '0;
      floaded_q <= '0;
      fsent_q   <= '0;
      tvalid_q  <= 1'b0;
      sof_q     <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wcnt_q    <= wcnt_d;
      gap_q     <= gap_d;
      gcnt_q    <= gcnt_d;
      num_q     <= num_d;
      floaded_q <= floaded_d;
      fsent_q   <= fsent_d;
      tvalid_q  <= tvalid_d;
      sof_q     <= sof_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      done_q    <= done_d;
    end
  end

  // The output register may take a new word only when it is empty or its
  // current word is being accepted this cycle.
  assign slot_free    = !tvalid_q || m_axis_tready;
  assign word_is_last = (wcnt_q == len_q - 1'b1);
  assign floaded_inc  = floaded_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    gap_d     = gap_q;
    gcnt_d    = gcnt_q;
    num_d     = num_q;
    floaded_d = floaded_q;
    fsent_d   = fsent_q;
    tvalid_d  = tvalid_q;
    sof_d     = sof_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    done_d    = 1'b0;
    load_c    = 1'b0;
    adv_c     = 1'b0;

    if (tvalid_q && m_axis_tready && tlast_q) begin
      fsent_d = fsent_q + 1'b1;
    end

    // An accepted or empty slot becomes empty unless a load below refills it.
    if (slot_free) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort && (i_frame_len != '0)) begin
          len_d     = i_frame_len;
          gap_d     = i_gap_len;
          num_d     = i_num_frames;
          wcnt_d    = '0;
          gcnt_d    = '0;
          floaded_d = '0;
          fsent_d   = '0;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        load_c  = 1'b1;
        state_d = i_abort ? ST_DRAIN : ST_SEND;
      end

      ST_SEND: begin
        // Abort takes priority over a load so that a partial frame stops
        // immediately; the word already held is still delivered in DRAIN.
        if (i_abort) begin
          state_d = ST_DRAIN;
        end else if (slot_free) begin
          adv_c    = 1'b1;
          tvalid_d = 1'b1;
          tdata_d  = i_prbs_data;
          sof_d    = (wcnt_q == '0);
          tlast_d  = word_is_last;
          if (word_is_last) begin
            wcnt_d    = '0;
            floaded_d = floaded_inc;
            if ((num_q != '0) && (floaded_inc == num_q)) begin
              state_d = ST_DRAIN;
            end else if (gap_q != '0) begin
              gcnt_d  = '0;
              state_d = ST_GAP;
            end
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (i_abort) begin
          state_d = ST_DRAIN;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
          if (gcnt_q == gap_q - 1'b1) begin
            state_d = ST_SEND;
          end
        end
      end

      ST_DRAIN: begin
        if (slot_free) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_prbs_load    = load_c;
  assign o_prbs_advance = adv_c;
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_sof     = sof_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tdata   = tdata_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = done_q;
  assign o_frames_sent  = fsent_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
module tb_tx_frame_scheduler;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] frame_len = '0;
  logic [7:0]  gap_len = '0;
  logic [15:0] num_frames = '0;
  logic [31:0] seed = '0;
  logic        prbs_load;
  logic        prbs_adv;
  logic [31:0] gen = '0;
  logic        tready = 1'b0;
  logic        tvalid;
  logic        sof;
  logic        tlast;
  logic [31:0] tdata;
  logic        busy;
  logic        done;
  logic [15:0] frames_sent;

  always #5 clk = ~clk;

  tx_frame_scheduler dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rstn),
    .i_start        (start),
    .i_abort        (abort),
    .i_frame_len    (frame_len),
    .i_gap_len      (gap_len),
    .i_num_frames   (num_frames),
    .i_seed         (seed),
    .o_prbs_load    (prbs_load),
    .o_prbs_advance (prbs_adv),
    .i_prbs_data    (gen),
    .m_axis_tready  (tready),
    .m_axis_tvalid  (tvalid),
    .m_axis_sof     (sof),
    .m_axis_tlast   (tlast),
    .m_axis_tdata   (tdata),
    .o_busy         (busy),
    .o_done         (done),
    .o_frames_sent  (frames_sent)
  );

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // PRBS generator model: word changes the cycle after load/advance.
  initial forever begin
    @(posedge clk);
    if (prbs_load) gen <= seed;
    else if (prbs_adv) gen <= xs_step(gen);
  end

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        l;
  } beat_t;

  beat_t q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    hs_cnt = 0;
  int    done_cnt = 0;
  int    done_base = 0;
  int    last_hs_cyc = 0;
  int    tlast_cyc = 0;
  bit    have_tlast = 0;
  bit    chk_gap = 0;
  int    exp_gap = 0;
  bit    prev_stall = 0;
  beat_t prev_b;
  int    rdy_mode = 0;
  logic  tready_man = 1'b1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: word k of a run is the k-th generator state from the seed;
  // its frame position is k mod len.
  task automatic push_run(input logic [31:0] s, input int len, input int nbeats);
    logic [31:0] w;
    beat_t b;
    w = s;
    for (int k = 0; k < nbeats; k++) begin
      b.d = w;
      b.s = ((k % len) == 0);
      b.l = ((k % len) == len - 1);
      q.push_back(b);
      w = xs_step(w);
    end
  endtask

  // tready driver: 0 manual, 1 fixed 1,0,0,1 pattern, 2 random.
  initial begin
    int idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        1: begin
          tready = (idx % 4 == 0) || (idx % 4 == 3);
          idx++;
        end
        2: tready = 1'($urandom_range(0, 1));
        default: tready = tready_man;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    beat_t e;
    @(negedge clk);
    cyc++;
    if (!rstn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, prev_b.d);
        chk("hold_sof", sof, prev_b.s);
        chk("hold_last", tlast, prev_b.l);
      end
      if (tvalid && !tready) chk("adv_while_stall", prbs_adv, 0);
      if (tvalid && tready) begin
        hs_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got data %0h expected no beat", tdata);
        end else begin
          e = q.pop_front();
          chk("beat_data", tdata, e.d);
          chk("beat_sof", sof, e.s);
          chk("beat_last", tlast, e.l);
        end
        if (chk_gap && sof && have_tlast) chk("gap_cycles", cyc - tlast_cyc, exp_gap + 1);
        if (tlast) begin
          have_tlast = 1;
          tlast_cyc  = cyc;
        end
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_latency", cyc - last_hs_cyc, 1);
        chk("done_busy", busy, 0);
        chk("done_queue_empty", q.size(), 0);
      end
      prev_stall = tvalid && !tready;
      prev_b     = '{d: tdata, s: sof, l: tlast};
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_sof"}, sof, 0);
    chk({tag, "_tlast"}, tlast, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fsent"}, frames_sent, 0);
    chk({tag, "_load"}, prbs_load, 0);
    chk({tag, "_adv"}, prbs_adv, 0);
  endtask

  task automatic start_run(input logic [31:0] s, input int len, input int gap, input int num);
    @(posedge clk);
    #1;
    seed       = s;
    frame_len  = 16'(len);
    gap_len    = 8'(gap);
    num_frames = 16'(num);
    have_tlast = 0;
    hs_cnt     = 0;
    done_base  = done_cnt;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({name, "_done_seen"}, done_cnt != done_base, 1);
  endtask

  task automatic pulse_idle(input string name, input int len, input logic ab);
    bit act;
    @(posedge clk);
    #1;
    frame_len = 16'(len);
    start     = 1'b1;
    abort     = ab;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    act   = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || tvalid || prbs_load) act = 1;
    end
    chk({name, "_no_activity"}, act, 0);
  endtask

  initial begin
    int n;
    logic [31:0] s;
    int len, gap, num;

    rdy_mode   = 0;
    tready_man = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Two framed bursts with a two-cycle gap and start latency checks.
    chk_gap = 1;
    exp_gap = 2;
    push_run(32'h1, 4, 8);
    start_run(32'h1, 4, 2, 2);
    @(negedge clk);
    chk("lat_load", prbs_load, 1);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_send_adv", prbs_adv, 1);
    chk("lat_send_tvalid", tvalid, 0);
    @(negedge clk);
    chk("lat_beat_valid", tvalid, 1);
    chk("lat_beat_data", tdata, 32'h1);
    chk("lat_beat_sof", sof, 1);
    wait_done("frames", 200);
    chk("frames_sent", frames_sent, 2);

    // Backpressure with a repeating ready pattern.
    chk_gap  = 0;
    rdy_mode = 1;
    s = 32'hC0FFEE11;
    push_run(s, 3, 6);
    start_run(s, 3, 1, 2);
    wait_done("bp", 300);
    chk("bp_frames_sent", frames_sent, 2);

    // Abort in continuous mode while a beat is held.
    rdy_mode   = 0;
    tready_man = 1'b1;
    s = 32'h12345678;
    push_run(s, 4, 6);
    start_run(s, 4, 1, 0);
    n = 0;
    while (hs_cnt < 5 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1 tready_man = 1'b0;
    chk("abort_reach5", hs_cnt >= 5, 1);
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 tready_man = 1'b1;
    wait_done("abort", 100);
    repeat (5) @(negedge clk);
    chk("abort_frames_sent", frames_sent, 1);
    chk("abort_beats", hs_cnt, 6);

    // Single-word frames back to back.
    chk_gap = 1;
    exp_gap = 0;
    s = 32'hA5A50001;
    push_run(s, 1, 3);
    start_run(s, 1, 0, 3);
    wait_done("len1", 100);
    chk("len1_frames_sent", frames_sent, 3);
    chk_gap = 0;

    // Starts that must not begin a run.
    pulse_idle("len0", 0, 1'b0);
    pulse_idle("start_abort", 3, 1'b1);

    // Start while busy is ignored and the counter is not cleared.
    s = 32'h0BADF00D;
    push_run(s, 3, 9);
    start_run(s, 3, 2, 3);
    n = 0;
    while (frames_sent != 16'd1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("busy_reach_frame1", frames_sent, 1);
    @(posedge clk);
    #1;
    seed = 32'hDEAD0001;
    frame_len = 16'd2;
    num_frames = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_start_fsent_kept", frames_sent != 16'd0, 1);
    wait_done("busy_start", 300);
    chk("busy_start_frames_sent", frames_sent, 3);

    // Randomized runs against the reference model.
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      s   = $urandom | 32'h1;
      len = $urandom_range(1, 5);
      gap = $urandom_range(0, 3);
      num = $urandom_range(1, 3);
      push_run(s, len, len * num);
      start_run(s, len, gap, num);
      wait_done("rand", 2000);
      chk("rand_frames_sent", frames_sent, 16'(num));
      repeat ($urandom_range(1, 4)) @(posedge clk);
    end

    // Reset in the middle of a frame, then a clean run.
    rdy_mode   = 0;
    tready_man = 1'b1;
    s = 32'h00C0DE01;
    push_run(s, 5, 10);
    start_run(s, 5, 0, 2);
    n = 0;
    while (hs_cnt < 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #3 rstn = 1'b0;
    #1;
    check_zero("midreset");
    q.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    s = 32'h77770003;
    chk_gap = 1;
    exp_gap = 1;
    push_run(s, 2, 4);
    start_run(s, 2, 1, 2);
    wait_done("after_reset", 200);
    chk("after_reset_frames_sent", frames_sent, 2);
    chk("after_reset_queue", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
